// File: rtl/aes_issue_arbiter_pkg.sv
// Shared types for the AES issue arbiter: block width, block type and the
// response record that travels through the response FIFO.
package aes_issue_arbiter_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_MAX_REQ = 8;
    localparam int AES_ID_W    = $clog2(AES_MAX_REQ);

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef struct packed {
        logic [AES_ID_W-1:0] id;
        aes_block_t          ciphertext;
    } aes_rsp_t;

endpackage

// File: rtl/aes_issue_arbiter_rsp_fifo.sv
// Response FIFO with a registered head entry: out_valid/out_data are flops,
// and a push into an empty FIFO is visible the very next cycle.
module aes_rsp_fifo
    import aes_issue_arbiter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  aes_rsp_t push_data,
    input  logic     pop,
    output logic     out_valid,
    output aes_rsp_t out_data
);

    localparam int PW = $clog2(DEPTH);

    aes_rsp_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          out_valid_q, out_valid_d;
    aes_rsp_t      out_q, out_d;
    logic          head_free, take, mem_wr;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        mem_wr      = 1'b0;
        take        = 1'b0;
        // The head slot frees when it is empty or being popped; refill it
        // from storage first, otherwise straight from the incoming push.
        head_free   = !out_valid_q || pop;
        if (head_free) begin
            if (cnt_q != '0) begin
                take        = 1'b1;
                out_d       = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PW'(1);
                mem_wr      = push;
            end else begin
                out_valid_d = push;
                if (push) out_d = push_data;
            end
        end else begin
            mem_wr = push;
        end
        if (mem_wr) wr_ptr_d = wr_ptr_q + PW'(1);
        cnt_d = cnt_q + (PW+1)'(mem_wr) - (PW+1)'(take);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_wr) mem_q[wr_ptr_q] <= push_data;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: rtl/aes_issue_arbiter.sv
// Round-robin issue arbiter in front of a fixed-latency AES-128 core, with
// credit-protected response buffering. AES_ISSUE_ARB_PERF_EN adds perf counters.
module aes_issue_arbiter
    import aes_issue_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*128-1:0]       req_key,
    input  logic [NUM_REQ*128-1:0]       req_plaintext,
    output logic [127:0]                 core_key,
    output logic [127:0]                 core_plaintext,
    input  logic [127:0]                 core_ciphertext,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [127:0]                 rsp_ciphertext,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic                         busy
`ifdef AES_ISSUE_ARB_PERF_EN
    ,
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_stalled
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0]              credit_q, credit_d;
    logic [IDW-1:0]             ptr_q, ptr_d, grant_idx;
    logic                       grant_vld, issue, pop;
    aes_block_t                 core_key_q, core_key_d, core_pt_q, core_pt_d;
    // One stage beyond LATENCY covers the core input register, so the tail
    // stage lines up with the cycle core_ciphertext is valid.
    logic [LATENCY:0]           dl_vld_q, dl_vld_d;
    logic [LATENCY:0][IDW-1:0]  dl_id_q, dl_id_d;
    aes_rsp_t                   push_data, rsp_q;
    int                         cand;
    logic                       unused_rsp_id;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
            end
        end
    end

    assign req_ready = (grant_vld && credit_q != '0 && !reset) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign issue     = |(req_valid & req_ready);
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        credit_d   = credit_q - CW'(issue) + CW'(pop);
        ptr_d      = ptr_q;
        core_key_d = core_key_q;
        core_pt_d  = core_pt_q;
        if (issue) begin
            ptr_d      = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
            core_key_d = req_key[grant_idx*AES_BLOCK_W +: AES_BLOCK_W];
            core_pt_d  = req_plaintext[grant_idx*AES_BLOCK_W +: AES_BLOCK_W];
        end
        dl_vld_d             = {dl_vld_q[LATENCY-1:0], issue};
        dl_id_d              = {dl_id_q[LATENCY-1:0], grant_idx};
        push_data.id         = AES_ID_W'(dl_id_q[LATENCY]);
        push_data.ciphertext = core_ciphertext;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q   <= CW'(FIFO_DEPTH);
            ptr_q      <= '0;
            core_key_q <= '0;
            core_pt_q  <= '0;
            dl_vld_q   <= '0;
            dl_id_q    <= '0;
        end else begin
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
            core_key_q <= core_key_d;
            core_pt_q  <= core_pt_d;
            dl_vld_q   <= dl_vld_d;
            dl_id_q    <= dl_id_d;
        end
    end

    aes_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (dl_vld_q[LATENCY]),
        .push_data (push_data),
        .pop       (pop),
        .out_valid (rsp_valid),
        .out_data  (rsp_q)
    );

    assign core_key       = core_key_q;
    assign core_plaintext = core_pt_q;
    assign rsp_ciphertext = rsp_q.ciphertext;
    assign rsp_id         = rsp_q.id[IDW-1:0];
    assign unused_rsp_id  = ^rsp_q.id;
    assign busy           = credit_q != CW'(FIFO_DEPTH);

`ifdef AES_ISSUE_ARB_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d, perf_stalled_q, perf_stalled_d;

    always_comb begin
        perf_issued_d  = perf_issued_q + 32'(issue);
        perf_stalled_d = perf_stalled_q + 32'(|req_valid && credit_q == '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issued_q  <= '0;
            perf_stalled_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_stalled_q <= perf_stalled_d;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_stalled = perf_stalled_q;
`endif

endmodule

// File: tb/tb_aes_issue_arbiter.sv
// Directed bench for aes_issue_arbiter with a behavioural fixed-latency core
// and an in-order response scoreboard.
module tb_aes_issue_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int LATENCY    = 11;
    localparam int FIFO_DEPTH = 16;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_key = '0;
    logic [NUM_REQ*128-1:0] req_plaintext = '0;
    logic [127:0]           core_key, core_plaintext, core_ciphertext;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [127:0]           rsp_ciphertext;
    logic [1:0]             rsp_id;
    logic                   busy;
`ifdef AES_ISSUE_ARB_PERF_EN
    logic [31:0]            perf_issued, perf_stalled;
`endif

    aes_issue_arbiter #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
`ifdef AES_ISSUE_ARB_PERF_EN
        .perf_issued     (perf_issued),
        .perf_stalled    (perf_stalled),
`endif
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_key         (req_key),
        .req_plaintext   (req_plaintext),
        .core_key        (core_key),
        .core_plaintext  (core_plaintext),
        .core_ciphertext (core_ciphertext),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_ciphertext  (rsp_ciphertext),
        .rsp_id          (rsp_id),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    // Stand-in core: known answer for the FIPS-197 vector, a cheap mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0123_4567_89ab_cdef_f00d_1357_2468;
    endfunction

    logic [127:0] core_pipe [LATENCY];
    always @(posedge clock) begin
        core_pipe[0] <= core_fn(core_key, core_plaintext);
        for (int i = 1; i < LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_ciphertext = core_pipe[LATENCY-1];

    typedef struct { logic [1:0] id; logic [127:0] ct; } exp_t;
    typedef struct { logic [3:0] valid; logic [3:0] exp_ready; } vec_t;

    exp_t sb[$];
    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Any response handed over at the coming edge must match the oldest expected block.
    task automatic tick();
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d ct %0h with nothing outstanding", rsp_id, rsp_ciphertext);
            end else begin
                e = sb.pop_front();
                check("rsp_id", 128'(rsp_id), 128'(e.id));
                check("rsp_ct", rsp_ciphertext, e.ct);
            end
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] key_of(input int i);
        return {4{32'h0f1e_2d3c ^ (32'(i) * 32'h0101_0101)}};
    endfunction

    function automatic logic [127:0] pt_of(input int seed, input int i);
        return {32'(seed), 32'hcafe_0000 | 32'(i), 32'(seed * 7), 32'(i + 3)};
    endfunction

    task automatic set_data(input int seed);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_key[i*128 +: 128]       = key_of(i);
            req_plaintext[i*128 +: 128] = pt_of(seed, i);
        end
    endtask

    task automatic expect_issue(input logic [3:0] rdy, input int seed);
        for (int i = 0; i < NUM_REQ; i++)
            if (rdy[i]) sb.push_back('{id: 2'(i), ct: core_fn(key_of(i), pt_of(seed, i))});
    endtask

    task automatic do_reset();
        rsp_ready = 1'b0;
        req_valid = '0;
        reset     = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        sb.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 80) begin
            tick();
            n++;
        end
        check({name, "_idle"}, 128'(busy), 128'(0));
        check({name, "_sb_empty"}, 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int n;
        int seen;
        logic [3:0] exp;

        tbl[0]  = '{4'b1111, 4'b0010};  tbl[1]  = '{4'b1111, 4'b0100};
        tbl[2]  = '{4'b1111, 4'b1000};  tbl[3]  = '{4'b1111, 4'b0001};
        tbl[4]  = '{4'b1111, 4'b0010};  tbl[5]  = '{4'b1111, 4'b0100};
        tbl[6]  = '{4'b1111, 4'b1000};  tbl[7]  = '{4'b1111, 4'b0001};
        tbl[8]  = '{4'b0000, 4'b0000};  tbl[9]  = '{4'b0001, 4'b0001};
        tbl[10] = '{4'b1001, 4'b1000};  tbl[11] = '{4'b0110, 4'b0010};
        tbl[12] = '{4'b0010, 4'b0010};  tbl[13] = '{4'b1100, 4'b0100};
        tbl[14] = '{4'b0101, 4'b0001};  tbl[15] = '{4'b0000, 4'b0000};

        // Reset values, with requests already pending.
        req_valid = 4'b1111;
        set_data(0);
        tick();
        tick();
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_ct", rsp_ciphertext, 128'(0));
        check("rst_rsp_id", 128'(rsp_id), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_core_key", core_key, 128'(0));
        check("rst_core_pt", core_plaintext, 128'(0));
        reset     = 1'b0;
        req_valid = '0;
        tick();

        // Single FIPS-197 block from requester 0.
        req_key[127:0]       = FIPS_KEY;
        req_plaintext[127:0] = FIPS_PT;
        req_valid            = 4'b0001;
        rsp_ready            = 1'b1;
        #1;
        check("fips_ready", 128'(req_ready), 128'(4'b0001));
        sb.push_back('{id: 2'd0, ct: FIPS_CT});
        tick();
        req_valid = '0;
        check("fips_core_key", core_key, FIPS_KEY);
        check("fips_core_pt", core_plaintext, FIPS_PT);
        check("fips_busy", 128'(busy), 128'(1));
        n = 1;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check("fips_latency", 128'(n), 128'(LATENCY + 2));
        check("fips_ct", rsp_ciphertext, FIPS_CT);
        check("fips_id", 128'(rsp_id), 128'(0));
        tick();
        check("fips_rsp_gone", 128'(rsp_valid), 128'(0));
        check("fips_idle", 128'(busy), 128'(0));

        // Round-robin table; pointer starts at 1 after the grant to requester 0.
        for (int r = 0; r < 16; r++) begin
            req_valid = tbl[r].valid;
            set_data(100 + r);
            #1;
            check($sformatf("rr_ready_%0d", r), 128'(req_ready), 128'(tbl[r].exp_ready));
            expect_issue(tbl[r].exp_ready, 100 + r);
            tick();
        end
        req_valid = '0;
        wait_idle("rr");

        // Backpressure: requester 2 only, consumer stalled.
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 24; c++) begin
            set_data(200 + c);
            exp = (c < FIFO_DEPTH) ? 4'b0100 : 4'b0000;
            #1;
            check($sformatf("bp_ready_%0d", c), 128'(req_ready), 128'(exp));
            expect_issue(exp, 200 + c);
            tick();
        end
        check("bp_busy", 128'(busy), 128'(1));
        rsp_ready = 1'b1;
        #1;
        check("bp_pop_cycle_ready", 128'(req_ready), 128'(0));
        tick();
        rsp_ready = 1'b0;
        set_data(300);
        #1;
        check("bp_refill_ready", 128'(req_ready), 128'(4'b0100));
        expect_issue(4'b0100, 300);
        tick();
        check("bp_full_again", 128'(req_ready), 128'(0));
        check("bp_busy_again", 128'(busy), 128'(1));
        tick();
        req_valid = '0;
`ifdef AES_ISSUE_ARB_PERF_EN
        check("perf_issued", 128'(perf_issued), 128'(17));
        check("perf_stalled", 128'(perf_stalled), 128'(10));
`endif
        rsp_ready = 1'b1;
        wait_idle("bp");

        // Drain to credit 1, then issue and pop together every cycle.
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        for (int c = 0; c < FIFO_DEPTH - 1; c++) begin
            set_data(400 + c);
            #1;
            check($sformatf("sim_fill_%0d", c), 128'(req_ready), 128'(4'b0001));
            expect_issue(4'b0001, 400 + c);
            tick();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            set_data(500 + c);
            #1;
            check($sformatf("sim_ready_%0d", c), 128'(req_ready), 128'(4'b0001));
            expect_issue(4'b0001, 500 + c);
            tick();
        end
        req_valid = '0;
        wait_idle("sim");

        // Reset with three blocks in flight.
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            set_data(600 + c);
            #1;
            check($sformatf("mid_ready_%0d", c), 128'(req_ready), 128'(4'b0001));
            tick();
        end
        req_valid = '0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        check("mid_core_key", core_key, 128'(0));
        check("mid_core_pt", core_plaintext, 128'(0));
        check("mid_busy", 128'(busy), 128'(0));
        req_valid = 4'b0011;
        #1;
        check("mid_ptr", 128'(req_ready), 128'(4'b0001));
        req_valid = '0;
        seen = 0;
        repeat (20) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("mid_no_rsp", 128'(seen), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
